// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - PS/2 key event FIFO with 512-entry key-down map
// Queues {pressed, extended, code} on each ps2_key toggle; CPU pops via rd strobe.
module ps2_key_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic [10:0]   ps2_key,
   input  logic          rd,
   input  logic          clr_ovf,
   output logic [9:0]    dout,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          q_ext,
   input  logic [7:0]    q_code,
   output logic          q_down
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic            r_prev_tog;
   logic [9:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wp;
   logic [AW-1:0]   r_rp;
   logic [AW:0]     r_count;
   logic            r_overflow;
   logic [511:0]    r_map;
   logic            r_q_down;

   logic            w_evt;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic [8:0]      w_wr_idx;
   logic [8:0]      w_q_idx;

   assign w_evt    = ps2_key[10] ^ r_prev_tog;
   assign empty    = (r_count == '0);
   assign full     = (r_count == LP_DEPTH);
   assign w_pop    = rd & ~empty & ~reset;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_push   = w_evt & ~reset & (~full | w_pop);
   assign w_drop   = w_evt & ~reset & full & ~w_pop;
   assign w_wr_idx = {ps2_key[8], ps2_key[7:0]};
   assign w_q_idx  = {q_ext, q_code};

   assign dout     = r_mem[r_rp];
   assign count    = r_count;
   assign overflow = r_overflow;
   assign q_down   = r_q_down;

   // Tracks the toggle even in reset so no phantom event follows release.
   always_ff @(posedge clk_sys) begin
      r_prev_tog <= ps2_key[10];
   end

   always_ff @(posedge clk_sys) begin
      if (w_push) begin
         r_mem[r_wp] <= ps2_key[9:0];
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wp <= r_wp + 1'b1;
         end
         if (w_pop) begin
            r_rp <= r_rp + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   // Dropped events still update the map; the query reads the pre-write value.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_map    <= '0;
         r_q_down <= 1'b0;
      end else begin
         r_q_down <= r_map[w_q_idx];
         if (w_evt) begin
            r_map[w_wr_idx] <= ps2_key[9];
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb/tb_ps2_key_fifo.sv - self-checking bench for ps2_key_fifo
module tb_ps2_key_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic [10:0]   ps2_key;
   logic          rd;
   logic          clr_ovf;
   logic [9:0]    dout;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          overflow;
   logic          q_ext;
   logic [7:0]    q_code;
   logic          q_down;

   ps2_key_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ps2_key  (ps2_key),
      .rd       (rd),
      .clr_ovf  (clr_ovf),
      .dout     (dout),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .q_ext    (q_ext),
      .q_code   (q_code),
      .q_down   (q_down)
   );

   always #5 clk_sys = ~clk_sys;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [9:0]  m_q [$];
   bit          m_ovf;
   bit          m_map [512];
   bit          m_qd;
   logic        tog;
   logic [9:0]  last_pop;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic verify();
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("full", 32'(full), 32'(m_q.size() == DEPTH));
      check("count", 32'(count), 32'(m_q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("q_down", 32'(q_down), 32'(m_qd));
      if (m_q.size() != 0) begin
         check("dout", 32'(dout), 32'(m_q[0]));
      end
   endtask

   task automatic step(input bit flip, input logic [9:0] data, input bit r, input bit c,
                       input bit qe, input logic [7:0] qc);
      int sz;
      bit pop;
      if (flip) tog = ~tog;
      ps2_key = {tog, data};
      rd      = r;
      clr_ovf = c;
      q_ext   = qe;
      q_code  = qc;
      reset   = 1'b0;
      @(posedge clk_sys);
      sz   = m_q.size();
      pop  = r && (sz > 0);
      m_qd = m_map[{qe, qc}];
      if (flip) m_map[{data[8], data[7:0]}] = data[9];
      if (pop) begin
         last_pop = m_q[0];
         m_q.delete(0);
      end
      if (flip && (sz < DEPTH || pop)) begin
         m_q.push_back(data);
      end else if (flip) begin
         m_ovf = 1'b1;
      end else if (c) begin
         m_ovf = 1'b0;
      end
      if (flip && !(sz < DEPTH || pop)) begin
         // set wins over clear
      end else if (flip && c) begin
         m_ovf = 1'b0;
      end
      #1 verify();
   endtask

   task automatic do_reset(input bit flip, input bit r);
      if (flip) tog = ~tog;
      ps2_key = {tog, 10'($urandom)};
      rd      = r;
      clr_ovf = 1'b0;
      reset   = 1'b1;
      @(posedge clk_sys);
      m_q.delete();
      m_ovf = 1'b0;
      m_qd  = 1'b0;
      for (int i = 0; i < 512; i++) m_map[i] = 1'b0;
      #1 verify();
      reset = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      tog = 1'b0;
      m_ovf = 1'b0;
      q_ext = 1'b0;
      q_code = 8'h00;
      do_reset(1'b0, 1'b0);
      do_reset(1'b0, 1'b0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_count", 32'(count), 32'd0);

      // Press A
      step(1'b1, 10'h21C, 1'b0, 1'b0, 1'b0, 8'h00);
      check("pressA_dout", 32'(dout), 32'h21C);
      check("pressA_count", 32'(count), 32'd1);
      step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("pressA_pop_empty", 32'(empty), 32'd1);

      // Fill with 17 events, back-to-back toggles
      for (int i = 1; i <= 17; i++) step(1'b1, 10'h200 | 10'(i), 1'b0, 1'b0, 1'b0, 8'h00);
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd16);
      check("fill_ovf", 32'(overflow), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         check("fill_order", 32'(dout), 32'(10'h200 | 10'(i)));
         step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 8'h00);
      end
      check("drain_empty", 32'(empty), 32'd1);
      step(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("clr_ovf", 32'(overflow), 32'd0);

      // Full plus simultaneous event and pop
      for (int i = 0; i < 16; i++) step(1'b1, 10'h260 | 10'(i), 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 10'h255, 1'b1, 1'b0, 1'b0, 8'h00);
      check("fullpop_count", 32'(count), 32'd16);
      check("fullpop_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 16; i++) step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("fullpop_last", 32'(last_pop), 32'h255);

      // rd when empty, then event plus rd on empty
      step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("rd_empty_count", 32'(count), 32'd0);
      step(1'b1, 10'h033, 1'b1, 1'b0, 1'b0, 8'h00);
      check("evt_rd_empty", 32'(count), 32'd1);
      check("evt_rd_dout", 32'(dout), 32'h033);

      // Reset mid-operation with toggle held high
      step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 8'h00);
      if (tog == 1'b0) step(1'b1, 10'h101, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) step(1'b1, 10'h240 | 10'(i), 1'b0, 1'b0, 1'b0, 8'h00);
      if (tog == 1'b0) step(1'b1, 10'h244, 1'b0, 1'b0, 1'b0, 8'h00);
      do_reset(1'b0, 1'b1);
      check("rst_mid_count", 32'(count), 32'd0);
      idle();
      idle();
      check("rst_no_evt", 32'(count), 32'd0);
      step(1'b1, 10'h2AA, 1'b0, 1'b0, 1'b0, 8'h00);
      check("rst_one_push", 32'(count), 32'd1);
      step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 8'h00);

      // Key map
      step(1'b1, 10'h375, 1'b1, 1'b0, 1'b0, 8'h75);
      step(1'b0, 10'h0, 1'b1, 1'b0, 1'b1, 8'h75);
      check("map_down", 32'(q_down), 32'd1);
      step(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 8'h75);
      check("map_noext", 32'(q_down), 32'd0);
      step(1'b1, 10'h175, 1'b0, 1'b0, 1'b1, 8'h75);
      check("map_prewrite", 32'(q_down), 32'd1);
      step(1'b0, 10'h0, 1'b1, 1'b0, 1'b1, 8'h75);
      check("map_release", 32'(q_down), 32'd0);

      // Randomized phases with varying pop pressure
      for (int ph = 0; ph < 6; ph++) begin
         int rd_pct;
         rd_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 85);
         for (int n = 0; n < 400; n++) begin
            logic [9:0] d;
            d = {1'($urandom), 1'($urandom), 8'($urandom_range(0, 15))};
            if ($urandom_range(0, 199) == 0) begin
               do_reset(1'($urandom), 1'($urandom));
            end else begin
               step(1'($urandom_range(0, 99) < 60), d,
                    1'($urandom_range(0, 99) < rd_pct),
                    1'($urandom_range(0, 99) < 10),
                    1'($urandom), 8'($urandom_range(0, 15)));
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
